// File: rtl/lf_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lf_pkg : shared state/direction types, voice command codes, error width helper
// Revision: 1.0
// -----------------------------------------------------------------------------
package lf_pkg;

   typedef enum logic [1:0] {
      ST_TRACK  = 2'd0,
      ST_SEARCH = 2'd1,
      ST_HALT   = 2'd2,
      ST_MANUAL = 2'd3
   } lf_state_e;

   typedef enum logic [1:0] {
      DIR_OFF = 2'd0,
      DIR_FWD = 2'd1,
      DIR_REV = 2'd2
   } motor_dir_e;

   localparam logic [2:0] CMD_AUTO  = 3'b000;
   localparam logic [2:0] CMD_FWD   = 3'b001;
   localparam logic [2:0] CMD_RIGHT = 3'b010;
   localparam logic [2:0] CMD_LEFT  = 3'b011;
   localparam logic [2:0] CMD_STOP  = 3'b100;
   localparam logic [2:0] CMD_REV   = 3'b101;

   function automatic int err_width(input int n);
      return $clog2(n * n) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lf_pwm_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lf_pwm_gen : free-running PWM with double-buffered duty/direction per motor
// Revision: 1.0
// -----------------------------------------------------------------------------
module lf_pwm_gen
   import lf_pkg::*;
#(
   parameter int PWM_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 force_off_i,
   input  logic [PWM_WIDTH-1:0] duty_l_i,
   input  logic [PWM_WIDTH-1:0] duty_r_i,
   input  logic [1:0]           dir_l_i,
   input  logic [1:0]           dir_r_i,
   output logic                 m1a_o,
   output logic                 m1b_o,
   output logic                 m2a_o,
   output logic                 m2b_o
);

   localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

   logic [PWM_WIDTH-1:0] cnt_d, cnt_q;
   logic [PWM_WIDTH-1:0] duty_l_d, duty_l_q, duty_r_d, duty_r_q;
   logic [1:0]           dir_l_d, dir_l_q, dir_r_d, dir_r_q;
   logic                 m1a_d, m1b_d, m2a_d, m2b_d;
   logic                 m1a_q, m1b_q, m2a_q, m2b_q;

   // Pins are computed from next-cycle counter/buffer values so the registered
   // pin lines up exactly with the registered counter.
   always_comb begin
      cnt_d    = cnt_q + 1'b1;
      duty_l_d = duty_l_q;
      duty_r_d = duty_r_q;
      dir_l_d  = dir_l_q;
      dir_r_d  = dir_r_q;
      if (force_off_i) begin
         duty_l_d = '0;
         duty_r_d = '0;
         dir_l_d  = DIR_OFF;
         dir_r_d  = DIR_OFF;
      end else if (cnt_q == CNT_MAX) begin
         duty_l_d = duty_l_i;
         duty_r_d = duty_r_i;
         dir_l_d  = dir_l_i;
         dir_r_d  = dir_r_i;
      end
      m1a_d = (dir_l_d == DIR_FWD) && (cnt_d < duty_l_d);
      m1b_d = (dir_l_d == DIR_REV) && (cnt_d < duty_l_d);
      m2a_d = (dir_r_d == DIR_FWD) && (cnt_d < duty_r_d);
      m2b_d = (dir_r_d == DIR_REV) && (cnt_d < duty_r_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         duty_l_q <= '0;
         duty_r_q <= '0;
         dir_l_q  <= DIR_OFF;
         dir_r_q  <= DIR_OFF;
         m1a_q    <= 1'b0;
         m1b_q    <= 1'b0;
         m2a_q    <= 1'b0;
         m2b_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         duty_l_q <= duty_l_d;
         duty_r_q <= duty_r_d;
         dir_l_q  <= dir_l_d;
         dir_r_q  <= dir_r_d;
         m1a_q    <= m1a_d;
         m1b_q    <= m1b_d;
         m2a_q    <= m2a_d;
         m2b_q    <= m2b_d;
      end
   end

   assign m1a_o = m1a_q;
   assign m1b_o = m1b_q;
   assign m2a_o = m2a_q;
   assign m2b_o = m2b_q;

endmodule
`default_nettype wire

// File: rtl/line_follower_pwm_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// line_follower_pwm_ctrl : N-sensor weighted steering, search/halt FSM, voice override
// Revision: 1.0
// -----------------------------------------------------------------------------
module line_follower_pwm_ctrl
   import lf_pkg::*;
#(
   parameter int NUM_SENSORS        = 5,
   parameter int PWM_WIDTH          = 8,
   parameter int STEER_STEP         = 40,
   parameter int CMD_HOLD_CYCLES    = 1000,
   parameter int LOST_SEARCH_CYCLES = 2000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SENSORS-1:0] sensors_i,
   input  logic [2:0]             cmd_i,
   input  logic                   cmd_valid_i,
   input  logic [PWM_WIDTH-1:0]   speed_base_i,
   output logic                   m1a_o,
   output logic                   m1b_o,
   output logic                   m2a_o,
   output logic                   m2b_o,
   output logic [1:0]             state_o
);

   localparam int ERR_W  = err_width(NUM_SENSORS);
   localparam int HALF   = (NUM_SENSORS - 1) / 2;
   localparam int HOLD_W = $clog2(CMD_HOLD_CYCLES + 1);
   localparam int SRCH_W = $clog2(LOST_SEARCH_CYCLES + 1);

   lf_state_e              state_d, state_q;
   logic [NUM_SENSORS-1:0] sensors_q;
   logic [HOLD_W-1:0]      hold_cnt_d, hold_cnt_q;
   logic [SRCH_W-1:0]      search_cnt_d, search_cnt_q;
   logic [2:0]             manual_cmd_d, manual_cmd_q;
   logic                   last_right_d, last_right_q;

   logic signed [ERR_W-1:0] err;
   logic [ERR_W-1:0]        abs_err;
   logic [31:0]             steer;
   logic [PWM_WIDTH-1:0]    inner_duty;
   logic                    any_active;
   logic                    is_move;
   logic [PWM_WIDTH-1:0]    duty_l, duty_r;
   logic [1:0]              dir_l, dir_r;

   always_comb begin
      err = '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         if (sensors_q[i]) err = err + ERR_W'(i - HALF);
      end
   end

   assign abs_err    = err[ERR_W-1] ? (~err + 1'b1) : err;
   assign steer      = 32'(abs_err) * 32'(STEER_STEP);
   assign inner_duty = (steer >= 32'(speed_base_i)) ? '0 : speed_base_i - PWM_WIDTH'(steer);
   assign any_active = |sensors_q;
   assign is_move    = cmd_valid_i && ((cmd_i == CMD_FWD) || (cmd_i == CMD_RIGHT) ||
                                       (cmd_i == CMD_LEFT) || (cmd_i == CMD_REV));

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_HALT;
      else     state_q <= state_d;
   end

   // A valid command overrides sensor- and timeout-driven transitions.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_TRACK:  if (!any_active) state_d = ST_SEARCH;
         ST_SEARCH: begin
            if (any_active) state_d = ST_TRACK;
            else if (search_cnt_q == SRCH_W'(LOST_SEARCH_CYCLES - 1)) state_d = ST_HALT;
         end
         ST_MANUAL: if (hold_cnt_q == HOLD_W'(CMD_HOLD_CYCLES - 1)) state_d = ST_TRACK;
         default:   state_d = ST_HALT;
      endcase
      if (cmd_valid_i) begin
         if (cmd_i == CMD_AUTO)      state_d = ST_TRACK;
         else if (cmd_i == CMD_STOP) state_d = ST_HALT;
         else if (is_move)           state_d = ST_MANUAL;
      end
   end

   always_comb begin
      duty_l = '0;
      duty_r = '0;
      dir_l  = DIR_OFF;
      dir_r  = DIR_OFF;
      case (state_q)
         ST_TRACK: begin
            dir_l  = DIR_FWD;
            dir_r  = DIR_FWD;
            duty_l = speed_base_i;
            duty_r = speed_base_i;
            if (err[ERR_W-1])      duty_l = inner_duty;
            else if (err != '0)    duty_r = inner_duty;
         end
         ST_SEARCH: begin
            duty_l = speed_base_i;
            duty_r = speed_base_i;
            dir_l  = last_right_q ? DIR_FWD : DIR_REV;
            dir_r  = last_right_q ? DIR_REV : DIR_FWD;
         end
         ST_MANUAL: begin
            case (manual_cmd_q)
               CMD_FWD: begin
                  dir_l = DIR_FWD; dir_r = DIR_FWD;
                  duty_l = speed_base_i; duty_r = speed_base_i;
               end
               CMD_RIGHT: begin
                  dir_l = DIR_FWD; duty_l = speed_base_i;
               end
               CMD_LEFT: begin
                  dir_r = DIR_FWD; duty_r = speed_base_i;
               end
               CMD_REV: begin
                  dir_l = DIR_REV; dir_r = DIR_REV;
                  duty_l = speed_base_i; duty_r = speed_base_i;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_comb begin
      search_cnt_d = ((state_q == ST_SEARCH) && (state_d == ST_SEARCH)) ? search_cnt_q + 1'b1 : '0;
      if (is_move)
         hold_cnt_d = '0;
      else if ((state_q == ST_MANUAL) && (state_d == ST_MANUAL))
         hold_cnt_d = hold_cnt_q + 1'b1;
      else
         hold_cnt_d = '0;
      manual_cmd_d = is_move ? cmd_i : manual_cmd_q;
      last_right_d = last_right_q;
      if ((state_q == ST_TRACK) && (err != '0)) last_right_d = ~err[ERR_W-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sensors_q    <= '0;
         hold_cnt_q   <= '0;
         search_cnt_q <= '0;
         manual_cmd_q <= CMD_FWD;
         last_right_q <= 1'b1;
      end else begin
         sensors_q    <= sensors_i;
         hold_cnt_q   <= hold_cnt_d;
         search_cnt_q <= search_cnt_d;
         manual_cmd_q <= manual_cmd_d;
         last_right_q <= last_right_d;
      end
   end

   lf_pwm_gen #(
      .PWM_WIDTH (PWM_WIDTH)
   ) u_pwm (
      .clk         (clk),
      .rst         (rst),
      .force_off_i (state_d == ST_HALT),
      .duty_l_i    (duty_l),
      .duty_r_i    (duty_r),
      .dir_l_i     (dir_l),
      .dir_r_i     (dir_r),
      .m1a_o       (m1a_o),
      .m1b_o       (m1b_o),
      .m2a_o       (m2a_o),
      .m2b_o       (m2b_o)
   );

   assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_line_follower_pwm_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// tb_line_follower_pwm_ctrl : directed vector table plus multi-cycle sequences
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_line_follower_pwm_ctrl;

   localparam int NV = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] sensors;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic [7:0] speed;
   logic       m1a, m1b, m2a, m2b;
   logic [1:0] state;

   int tests   = 0;
   int fails   = 0;
   int mon_err = 0;

   always #5 clk = ~clk;

   line_follower_pwm_ctrl #(
      .NUM_SENSORS        (5),
      .PWM_WIDTH          (8),
      .STEER_STEP         (40),
      .CMD_HOLD_CYCLES    (100),
      .LOST_SEARCH_CYCLES (300)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sensors_i    (sensors),
      .cmd_i        (cmd),
      .cmd_valid_i  (cmd_valid),
      .speed_base_i (speed),
      .m1a_o        (m1a),
      .m1b_o        (m1b),
      .m2a_o        (m2a),
      .m2b_o        (m2b),
      .state_o      (state)
   );

   // Period position: cleared by reset, then free-running mod 256.
   logic [7:0] tb_cnt;
   always @(posedge clk) begin
      if (rst) tb_cnt <= 8'd0;
      else     tb_cnt <= tb_cnt + 8'd1;
   end

   // Pin rules: a/b never both high, and no rising edge except at a period start.
   logic [3:0] prev_pins;
   logic [3:0] cur_pins;
   always @(negedge clk) begin
      cur_pins = {m1a, m1b, m2a, m2b};
      if (!rst) begin
         if ((cur_pins[3] && cur_pins[2]) || (cur_pins[1] && cur_pins[0])) mon_err++;
         if ((tb_cnt != 8'd0) && ((cur_pins & ~prev_pins) != 4'd0)) mon_err++;
      end
      prev_pins = cur_pins;
   end

   typedef struct {
      logic [4:0] sens;
      logic [7:0] spd;
      logic       use_cmd;
      logic [2:0] cmd;
      int         st;
      int         d1a, d1b, d2a, d2b;
   } vec_t;

   vec_t vecs [NV];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_cnt(input int c);
      int k;
      k = 0;
      @(negedge clk);
      while ((tb_cnt != 8'(c)) && (k < 600)) begin
         @(negedge clk);
         k++;
      end
      if (k >= 600) begin
         tests++;
         fails++;
         $display("FAIL wait_cnt_%0d: timed out, got cnt %0d", c, tb_cnt);
      end
   endtask

   task automatic strobe(input logic [2:0] c);
      cmd       = c;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Called at the negedge where cnt==0; ends at the negedge where cnt==255.
   task automatic measure(output int h1a, output int h1b, output int h2a, output int h2b);
      h1a = 0; h1b = 0; h2a = 0; h2b = 0;
      for (int i = 0; i < 256; i++) begin
         if (i != 0) @(negedge clk);
         h1a += int'(m1a);
         h1b += int'(m1b);
         h2a += int'(m2a);
         h2b += int'(m2b);
      end
   endtask

   task automatic apply_vec(input int i);
      int h1a, h1b, h2a, h2b;
      wait_cnt(250);
      sensors = vecs[i].sens;
      speed   = vecs[i].spd;
      if (vecs[i].use_cmd) strobe(vecs[i].cmd);
      wait_cnt(0);
      check($sformatf("v%0d_state", i), int'(state), vecs[i].st);
      measure(h1a, h1b, h2a, h2b);
      check($sformatf("v%0d_m1a_duty", i), h1a, vecs[i].d1a);
      check($sformatf("v%0d_m1b_duty", i), h1b, vecs[i].d1b);
      check($sformatf("v%0d_m2a_duty", i), h2a, vecs[i].d2a);
      check($sformatf("v%0d_m2b_duty", i), h2b, vecs[i].d2b);
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      sensors   = 5'b00100;
      cmd       = 3'b000;
      cmd_valid = 1'b0;
      speed     = 8'd200;

      //           sens      spd     cmd? cmd     st  1a   1b   2a   2b
      vecs[0]  = '{5'b00100, 8'd200, 1'b0, 3'b000, 2, 0,   0,   0,   0};
      vecs[1]  = '{5'b00100, 8'd200, 1'b1, 3'b000, 0, 200, 0,   200, 0};
      vecs[2]  = '{5'b11000, 8'd200, 1'b0, 3'b000, 0, 200, 0,   80,  0};
      vecs[3]  = '{5'b00011, 8'd200, 1'b0, 3'b000, 0, 80,  0,   200, 0};
      vecs[4]  = '{5'b11111, 8'd200, 1'b0, 3'b000, 0, 200, 0,   200, 0};
      vecs[5]  = '{5'b10000, 8'd200, 1'b0, 3'b000, 0, 200, 0,   120, 0};
      vecs[6]  = '{5'b00001, 8'd200, 1'b0, 3'b000, 0, 120, 0,   200, 0};
      vecs[7]  = '{5'b00110, 8'd200, 1'b0, 3'b000, 0, 160, 0,   200, 0};
      vecs[8]  = '{5'b00110, 8'd200, 1'b1, 3'b111, 0, 160, 0,   200, 0};
      vecs[9]  = '{5'b00100, 8'd200, 1'b1, 3'b101, 3, 0,   200, 0,   200};
      vecs[10] = '{5'b00100, 8'd200, 1'b1, 3'b010, 3, 200, 0,   0,   0};
      vecs[11] = '{5'b00100, 8'd200, 1'b1, 3'b011, 3, 0,   0,   200, 0};
      vecs[12] = '{5'b00100, 8'd200, 1'b1, 3'b001, 3, 200, 0,   200, 0};
      vecs[13] = '{5'b11000, 8'd200, 1'b0, 3'b000, 0, 200, 0,   80,  0};
      vecs[14] = '{5'b00000, 8'd200, 1'b0, 3'b000, 1, 200, 0,   0,   200};
      vecs[15] = '{5'b00011, 8'd200, 1'b1, 3'b000, 0, 80,  0,   200, 0};
      vecs[16] = '{5'b00000, 8'd200, 1'b0, 3'b000, 1, 0,   200, 200, 0};
      vecs[17] = '{5'b11000, 8'd100, 1'b1, 3'b000, 0, 100, 0,   0,   0};
      vecs[18] = '{5'b00100, 8'd255, 1'b0, 3'b000, 0, 255, 0,   255, 0};
      vecs[19] = '{5'b00100, 8'd255, 1'b1, 3'b100, 2, 0,   0,   0,   0};

      repeat (3) @(negedge clk);
      check("reset_state", int'(state), 2);
      check("reset_pins", int'({m1a, m1b, m2a, m2b}), 0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) apply_vec(i);

      // Hold lifetime: a single move command lasts exactly 100 cycles.
      speed   = 8'd200;
      sensors = 5'b00100;
      strobe(3'b000);
      repeat (3) @(negedge clk);
      strobe(3'b001);
      n = 0;
      while ((state == 2'd3) && (n < 1000)) begin
         n++;
         @(negedge clk);
      end
      check("hold_single_len", n, 100);
      check("hold_expire_state", int'(state), 0);

      // Re-strobe when the hold count is 80: 81 cycles, then a fresh 100.
      strobe(3'b101);
      n = 0;
      while ((state == 2'd3) && (n < 1000)) begin
         if (n == 80) begin
            cmd       = 3'b101;
            cmd_valid = 1'b1;
         end
         n++;
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      check("hold_restrobe_len", n, 181);
      check("hold_restrobe_state", int'(state), 0);

      // Stop mid-period forces pins low on the very next edge.
      wait_cnt(0);
      wait_cnt(0);
      wait_cnt(50);
      check("stop_pre_m1a", int'(m1a), 1);
      strobe(3'b100);
      check("stop_state", int'(state), 2);
      check("stop_pins", int'({m1a, m1b, m2a, m2b}), 0);

      // Search timeout: 300 cycles in SEARCH, then HALT with pins already low.
      sensors = 5'b11000;
      strobe(3'b000);
      repeat (4) @(negedge clk);
      sensors = 5'b00000;
      n = 0;
      while ((state != 2'd1) && (n < 10)) begin
         n++;
         @(negedge clk);
      end
      check("search_entry", int'(state), 1);
      n = 0;
      while ((state == 2'd1) && (n < 1000)) begin
         n++;
         @(negedge clk);
      end
      check("search_len", n, 300);
      check("search_halt_state", int'(state), 2);
      check("search_halt_pins", int'({m1a, m1b, m2a, m2b}), 0);

      // Reset in mid-SEARCH with last direction left; reset restores "right".
      sensors = 5'b00011;
      strobe(3'b000);
      repeat (4) @(negedge clk);
      sensors = 5'b00000;
      repeat (20) @(negedge clk);
      check("rst_pre_state", int'(state), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_state", int'(state), 2);
      check("rst_mid_pins", int'({m1a, m1b, m2a, m2b}), 0);
      rst = 1'b0;
      strobe(3'b000);
      wait_cnt(0);
      check("rst_search_state", int'(state), 1);
      check("rst_search_pins", int'({m1a, m1b, m2a, m2b}), 4'b1001);

      check("pin_rule_violations", mon_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
